// File: rtl/pe_conv_scheduler.sv
// -----------------------------------------------------------------------------
// pe_conv_scheduler
//
// Sequencer for one PE's 1-D convolution. For every output position i it walks
// the filter taps j, reads ifmap[i+j] and filter[j], hands the operand pair to
// the shared multiplier over a valid/ready handshake, accumulates the returned
// products, and presents one psum per output position to the packetizer.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start                begin a convolution pass (only honoured in IDLE)
//   busy, done           pass in progress / one-cycle completion pulse
//   mem_rd_en            read strobe for ifmap and filter memories
//   if_raddr, f_raddr    read addresses (i+j, j)
//   if_rdata, f_rdata    read data, one cycle after mem_rd_en
//   mul_valid/ready      operand handshake toward the multiplier
//   mul_a, mul_b         operands (ifmap, filter)
//   prod_valid, prod     product return (any latency >= 1)
//   out_valid/ready      psum handshake toward the packetizer
//   out_psum, out_idx    psum value and its output position
//
// Build option
//   PE_ACC_SAT_EN        when defined, the accumulator saturates at all-ones
//                        instead of wrapping modulo 2^PSUM_W.
// -----------------------------------------------------------------------------
module pe_conv_scheduler #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_I = 5,
    parameter int ADDR_I  = 3,
    parameter int DEPTH_F = 3,
    parameter int ADDR_F  = 2,
    parameter int PSUM_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd_en,
    output logic [ADDR_I-1:0]    if_raddr,
    output logic [ADDR_F-1:0]    f_raddr,
    input  logic [WIDTH-1:0]     if_rdata,
    input  logic [WIDTH-1:0]     f_rdata,
    output logic                 mul_valid,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_ready,
    input  logic                 prod_valid,
    input  logic [2*WIDTH-1:0]   prod,
    output logic                 out_valid,
    output logic [PSUM_W-1:0]    out_psum,
    output logic [ADDR_I-1:0]    out_idx,
    input  logic                 out_ready
);

    localparam int N_OUT = DEPTH_I - DEPTH_F + 1;
    // Sum width keeps the carry out of the accumulator add for either operand.
    localparam int SUM_W = ((2 * WIDTH) > PSUM_W) ? (2 * WIDTH + 1) : (PSUM_W + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_MUL  = 3'd3,
        S_ACC  = 3'd4,
        S_EMIT = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_I-1:0]   i_reg;
    logic [ADDR_F-1:0]   j_reg;
    logic [PSUM_W-1:0]   acc_reg;
    logic [WIDTH-1:0]    opa_reg, opb_reg;

    logic                last_tap, last_out;
    logic [SUM_W-1:0]    acc_sum;
    logic [PSUM_W-1:0]   acc_add;

    assign last_tap = (j_reg == ADDR_F'(DEPTH_F - 1));
    assign last_out = (i_reg == ADDR_I'(N_OUT - 1));
    assign acc_sum  = SUM_W'(acc_reg) + SUM_W'(prod);

`ifdef PE_ACC_SAT_EN
    // Products are unsigned, so once any carry leaves the accumulator it stays
    // pinned at all-ones until the next psum clears it.
    assign acc_add = (|acc_sum[SUM_W-1:PSUM_W]) ? {PSUM_W{1'b1}} : acc_sum[PSUM_W-1:0];
`else
    assign acc_add = acc_sum[PSUM_W-1:0];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start)      state_next = S_READ;
            S_READ:                  state_next = S_WAIT;
            S_WAIT:                  state_next = S_MUL;
            S_MUL:   if (mul_ready)  state_next = S_ACC;
            S_ACC:   if (prod_valid) state_next = last_tap ? S_EMIT : S_READ;
            S_EMIT:  if (out_ready)  state_next = last_out ? S_DONE : S_READ;
            S_DONE:                  state_next = S_IDLE;
            default:                 state_next = S_IDLE;
        endcase
    end

    // Loop counters, operand capture and accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_reg   <= '0;
            j_reg   <= '0;
            acc_reg <= '0;
            opa_reg <= '0;
            opb_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        i_reg   <= '0;
                        j_reg   <= '0;
                        acc_reg <= '0;
                    end
                end
                S_WAIT: begin
                    opa_reg <= if_rdata;
                    opb_reg <= f_rdata;
                end
                S_ACC: begin
                    if (prod_valid) begin
                        acc_reg <= acc_add;
                        if (!last_tap) begin
                            j_reg <= j_reg + ADDR_F'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready && !last_out) begin
                        i_reg   <= i_reg + ADDR_I'(1);
                        j_reg   <= '0;
                        acc_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the state so that every output is zero in IDLE
    // and the EMIT/MUL payloads stay stable for as long as the state is held.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd_en = 1'b0;
        if_raddr  = '0;
        f_raddr   = '0;
        mul_valid = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        out_valid = 1'b0;
        out_psum  = '0;
        out_idx   = '0;
        case (state_reg)
            S_READ: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                if_raddr  = i_reg + ADDR_I'(j_reg);
                f_raddr   = j_reg;
            end
            S_WAIT, S_ACC: begin
                busy = 1'b1;
            end
            S_MUL: begin
                busy      = 1'b1;
                mul_valid = 1'b1;
                mul_a     = opa_reg;
                mul_b     = opb_reg;
            end
            S_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_psum  = acc_reg;
                out_idx   = i_reg;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pe_conv_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pe_conv_scheduler
//
// Self-checking bench for pe_conv_scheduler. Models the ifmap/filter memories
// (one-cycle registered read) and a multiplier with configurable latency and
// optionally random ready. Expected psums come from the arithmetic definition
// psum[i] = sum_j ifmap[i+j]*filter[j], wrapped or clipped to 16 bits.
// -----------------------------------------------------------------------------
module tb_pe_conv_scheduler;

    localparam int WIDTH   = 8;
    localparam int DEPTH_I = 5;
    localparam int ADDR_I  = 3;
    localparam int DEPTH_F = 3;
    localparam int ADDR_F  = 2;
    localparam int PSUM_W  = 16;
    localparam int N_OUT   = DEPTH_I - DEPTH_F + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 busy, done, mem_rd_en;
    logic [ADDR_I-1:0]    if_raddr;
    logic [ADDR_F-1:0]    f_raddr;
    logic [WIDTH-1:0]     if_rdata = '0;
    logic [WIDTH-1:0]     f_rdata = '0;
    logic                 mul_valid;
    logic [WIDTH-1:0]     mul_a, mul_b;
    logic                 mul_ready = 1'b1;
    logic                 prod_valid;
    logic [2*WIDTH-1:0]   prod;
    logic                 out_valid;
    logic [PSUM_W-1:0]    out_psum;
    logic [ADDR_I-1:0]    out_idx;
    logic                 out_ready = 1'b1;

    pe_conv_scheduler #(
        .WIDTH(WIDTH), .DEPTH_I(DEPTH_I), .ADDR_I(ADDR_I),
        .DEPTH_F(DEPTH_F), .ADDR_F(ADDR_F), .PSUM_W(PSUM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .if_raddr(if_raddr), .f_raddr(f_raddr),
        .if_rdata(if_rdata), .f_rdata(f_rdata),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready),
        .prod_valid(prod_valid), .prod(prod),
        .out_valid(out_valid), .out_psum(out_psum), .out_idx(out_idx), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // ---------------- environment models ----------------
    logic [WIDTH-1:0] ifmap  [0:DEPTH_I-1];
    logic [WIDTH-1:0] filter [0:DEPTH_F-1];
    int               mul_lat = 1;
    bit               rand_ready = 1'b0;

    logic [2*WIDTH-1:0] pipe_p0 = '0, pipe_p1 = '0, pipe_p2 = '0;
    logic               pipe_v0 = 1'b0, pipe_v1 = 1'b0, pipe_v2 = 1'b0;

    // Memory read data is only meaningful the cycle after a read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            if_rdata <= (if_raddr < ADDR_I'(DEPTH_I)) ? ifmap[if_raddr] : 8'hA5;
            f_rdata  <= (f_raddr < ADDR_F'(DEPTH_F)) ? filter[f_raddr] : 8'h5A;
        end else begin
            if_rdata <= 8'($urandom);
            f_rdata  <= 8'($urandom);
        end
    end

    // Multiplier: accepts on valid&&ready, returns the product mul_lat cycles later.
    always @(posedge clk) begin
        pipe_v0   <= mul_valid && mul_ready;
        pipe_p0   <= 16'(mul_a) * 16'(mul_b);
        pipe_v1   <= pipe_v0;
        pipe_p1   <= pipe_p0;
        pipe_v2   <= pipe_v1;
        pipe_p2   <= pipe_p1;
        mul_ready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    assign prod_valid = (mul_lat == 3) ? pipe_v2 : pipe_v0;
    assign prod       = prod_valid ? ((mul_lat == 3) ? pipe_p2 : pipe_p0) : 16'hBEEF;

    // ---------------- monitors ----------------
    int   rd_count = 0;
    int   done_count = 0;
    int   stab_viol = 0;
    int   raddr_q [$];
    int   oidx_q [$];
    int   opsum_q [$];
    logic prev_mul_stall = 1'b0, prev_out_stall = 1'b0;
    logic [WIDTH-1:0]  prev_a = '0, prev_b = '0;
    logic [PSUM_W-1:0] prev_psum = '0;
    logic [ADDR_I-1:0] prev_idx = '0;

    always begin
        @(negedge clk);
        #1;
        if (mem_rd_en) begin
            rd_count++;
            raddr_q.push_back(int'(if_raddr));
        end
        if (done) done_count++;
        if (out_valid && out_ready) begin
            oidx_q.push_back(int'(out_idx));
            opsum_q.push_back(int'(out_psum));
        end
        if (prev_mul_stall && (!mul_valid || mul_a !== prev_a || mul_b !== prev_b)) stab_viol++;
        if (prev_out_stall && (!out_valid || out_psum !== prev_psum || out_idx !== prev_idx)) stab_viol++;
        prev_mul_stall = mul_valid && !mul_ready;
        prev_out_stall = out_valid && !out_ready;
        prev_a    = mul_a;
        prev_b    = mul_b;
        prev_psum = out_psum;
        prev_idx  = out_idx;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference psum from the arithmetic definition.
    function automatic longint ref_psum(input int i);
        longint s = 0;
        for (int j = 0; j < DEPTH_F; j++) s += longint'(ifmap[i+j]) * longint'(filter[j]);
`ifdef PE_ACC_SAT_EN
        if (s > longint'((1 << PSUM_W) - 1)) s = longint'((1 << PSUM_W) - 1);
`else
        s = s % longint'(1 << PSUM_W);
`endif
        return s;
    endfunction

    int p_rd0, p_dn0, p_q0, p_sv0, p_ra0;

    // Called at a negedge with the DUT idle; returns at the first out_valid.
    task automatic start_pass(input string tag, input bit chk_latency);
        int cyc;
        p_rd0 = rd_count;
        p_dn0 = done_count;
        p_q0  = opsum_q.size();
        p_sv0 = stab_viol;
        p_ra0 = raddr_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, longint'(busy), 1);
        cyc = 1;
        while (!out_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_first_out_seen"}, longint'(out_valid), 1);
        if (chk_latency) check({tag, "_first_out_latency"}, cyc, 4 * DEPTH_F + 1);
    endtask

    task automatic finish_pass(input string tag);
        int cyc = 0;
        int k = 0;
        while (done_count == p_dn0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, done_count - p_dn0, 1);
        check({tag, "_busy_after_done"}, longint'(busy), 0);
        check({tag, "_rd_count"}, rd_count - p_rd0, N_OUT * DEPTH_F);
        check({tag, "_stability_viol"}, stab_viol - p_sv0, 0);
        check({tag, "_psum_count"}, opsum_q.size() - p_q0, N_OUT);
        for (int i = 0; i < N_OUT; i++) begin
            check($sformatf("%s_idx%0d", tag, i),
                  (opsum_q.size() > p_q0 + i) ? longint'(oidx_q[p_q0+i]) : -1, i);
            check($sformatf("%s_psum%0d", tag, i),
                  (opsum_q.size() > p_q0 + i) ? longint'(opsum_q[p_q0+i]) : -1, ref_psum(i));
            for (int j = 0; j < DEPTH_F; j++) begin
                check($sformatf("%s_raddr%0d", tag, k),
                      (raddr_q.size() > p_ra0 + k) ? longint'(raddr_q[p_ra0+k]) : -1, i + j);
                k++;
            end
        end
    endtask

    task automatic load(input int a0, a1, a2, a3, a4, input int f0, f1, f2);
        ifmap[0] = 8'(a0); ifmap[1] = 8'(a1); ifmap[2] = 8'(a2);
        ifmap[3] = 8'(a3); ifmap[4] = 8'(a4);
        filter[0] = 8'(f0); filter[1] = 8'(f1); filter[2] = 8'(f2);
    endtask

    function automatic longint all_outputs();
        return longint'({busy, done, mem_rd_en, if_raddr, f_raddr, mul_valid,
                         mul_a, mul_b, out_valid, out_psum, out_idx});
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        load(1, 2, 3, 4, 5, 1, 1, 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", all_outputs(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs_zero", all_outputs(), 0);

        // 1: ramp ifmap, unit filter, latency of the first psum
        start_pass("t1", 1'b1);
        check("t1_first_psum", longint'(out_psum), 6);
        finish_pass("t1");

        // 2: non-uniform filter
        load(1, 2, 3, 4, 5, 2, 0, 1);
        start_pass("t2", 1'b1);
        finish_pass("t2");

        // 3: output back-pressure at the first psum
        load(1, 2, 3, 4, 5, 1, 1, 1);
        out_ready = 1'b0;
        start_pass("t3", 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t3_hold_valid%0d", c), longint'(out_valid), 1);
            check($sformatf("t3_hold_psum%0d", c), longint'(out_psum), 6);
        end
        out_ready = 1'b1;
        finish_pass("t3");

        // 4: random multiplier ready, three-cycle multiplier
        rand_ready = 1'b1;
        mul_lat = 3;
        start_pass("t4", 1'b0);
        finish_pass("t4");
        rand_ready = 1'b0;
        mul_lat = 1;
        repeat (4) @(negedge clk);

        // 5: full-scale operands (wrap or saturate)
        load(255, 255, 255, 255, 255, 255, 255, 255);
        start_pass("t5", 1'b1);
`ifdef PE_ACC_SAT_EN
        check("t5_first_psum", longint'(out_psum), 65535);
`else
        check("t5_first_psum", longint'(out_psum), 64003);
`endif
        finish_pass("t5");

        // 6: reset during the second tap of psum 1, then a clean rerun
        load(1, 2, 3, 4, 5, 1, 1, 1);
        p_dn0 = done_count;
        p_rd0 = rd_count;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (rd_count - p_rd0 < DEPTH_F + 2 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_reached_tap", rd_count - p_rd0, DEPTH_F + 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_reset_outputs_zero", all_outputs(), 0);
        repeat (8) @(negedge clk);
        check("t6_no_done_after_abort", done_count - p_dn0, 0);
        check("t6_idle_after_abort", all_outputs(), 0);
        start_pass("t6", 1'b1);
        start = 1'b1;                      // ignored: pass already running
        @(negedge clk);
        start = 1'b0;
        finish_pass("t6");

        // 7: random data, random ready, random multiplier latency
        for (int p = 0; p < 4; p++) begin
            for (int a = 0; a < DEPTH_I; a++) ifmap[a] = 8'($urandom);
            for (int f = 0; f < DEPTH_F; f++) filter[f] = 8'($urandom);
            rand_ready = 1'b1;
            mul_lat = ($urandom_range(0, 1) == 0) ? 1 : 3;
            start_pass($sformatf("t7r%0d", p), 1'b0);
            finish_pass($sformatf("t7r%0d", p));
            rand_ready = 1'b0;
            repeat (4) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
